// File: rtl/ctrl_pkg.sv
// Shared decode constants, control-bundle sizing and ALU-op enum for pipeline_controller.
// PIPELINE_CONTROLLER_DIV_EN adds div/divu decode and one extra bundle bit.
package ctrl_pkg;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_LUI   = 6'b001111;

    // R-type functs
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_XOR   = 6'b100110;
    localparam logic [5:0] FN_XNOR  = 6'b101000;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;

    // alucontrol encodings
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b1010;
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_XNOR = 4'b0101;
    localparam logic [3:0] ALU_SLT  = 4'b1011;

    // alusrc: register, sign-extended imm, zero-extended imm, imm<<16
    localparam logic [1:0] SRC_REG   = 2'd0;
    localparam logic [1:0] SRC_SEXT  = 2'd1;
    localparam logic [1:0] SRC_ZEXT  = 2'd2;
    localparam logic [1:0] SRC_UPPER = 2'd3;

    // regdst: rt, rd, $ra
    localparam logic [1:0] DST_RT = 2'd0;
    localparam logic [1:0] DST_RD = 2'd1;
    localparam logic [1:0] DST_RA = 2'd2;

    // Bundle width assumes the 4-bit reference alucontrol
    localparam int unsigned ALUCTRL_W_BASE = 4;
`ifdef PIPELINE_CONTROLLER_DIV_EN
    localparam int unsigned CTRL_BUNDLE_W = 17;
`else
    localparam int unsigned CTRL_BUNDLE_W = 16;
`endif

    typedef enum logic [2:0] {
        AOP_NONE,
        AOP_ADD,
        AOP_SUB,
        AOP_FUNCT,
        AOP_AND,
        AOP_OR,
        AOP_XOR,
        AOP_SLT
    } aluop_e;

    // Map the main-decoder ALU op (and funct for R-type) to alucontrol
    function automatic logic [3:0] aluop_ctrl(input aluop_e op, input logic [5:0] fn);
        logic [3:0] r;
        r = 4'b0000;
        case (op)
            AOP_ADD: r = ALU_ADD;
            AOP_SUB: r = ALU_SUB;
            AOP_AND: r = ALU_AND;
            AOP_OR:  r = ALU_OR;
            AOP_XOR: r = ALU_XOR;
            AOP_SLT: r = ALU_SLT;
            AOP_FUNCT: begin
                case (fn)
                    FN_ADD:  r = ALU_ADD;
                    FN_SUB:  r = ALU_SUB;
                    FN_AND:  r = ALU_AND;
                    FN_OR:   r = ALU_OR;
                    FN_XOR:  r = ALU_XOR;
                    FN_XNOR: r = ALU_XNOR;
                    FN_SLT:  r = ALU_SLT;
                    default: r = 4'b0000;
                endcase
            end
            default: r = 4'b0000;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mdu_scoreboard.sv
// MDU busy counter and HI/LO / back-to-back interlock for pipeline_controller.
// PIPELINE_CONTROLLER_DIV_EN enables the divide latency path.
module mdu_scoreboard #(
    parameter int unsigned MULT_CYCLES = 32,
    parameter int unsigned DIV_CYCLES  = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic mduop_i,
    input  logic multstart_i,
    input  logic div_i,
    output logic busy_o,
    output logic stall_o
);

`ifdef PIPELINE_CONTROLLER_DIV_EN
    localparam int unsigned MAX_CYCLES = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
`else
    localparam int unsigned MAX_CYCLES = MULT_CYCLES;
`endif
    localparam int unsigned CNT_W = $clog2(MAX_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] load_val;

`ifdef PIPELINE_CONTROLLER_DIV_EN
    assign load_val = div_i ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
`else
    logic unused_div;
    assign unused_div = div_i ^ (DIV_CYCLES != 0);
    assign load_val   = CNT_W'(MULT_CYCLES);
`endif

    // Load on a start, otherwise count down to zero
    always_comb begin
        cnt_d = cnt_q;
        if (multstart_i) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy_o  = (cnt_q != '0);
    // A start in E is not yet visible in the counter, so it stalls too
    assign stall_o = mduop_i & (busy_o | multstart_i);

endmodule

// File: rtl/pipeline_controller.sv
// MIPS 5-stage pipeline controller: decode in D, control bundle through E/M/W,
// MDU interlock and explicit illegal-instruction flag.
// PIPELINE_CONTROLLER_DIV_EN adds div/divu with a separate latency.
module pipeline_controller
    import ctrl_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 32,
    parameter int unsigned DIV_CYCLES  = 32,
    parameter int unsigned ALUCTRL_W   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [5:0]           opD,
    input  logic [5:0]           fnD,
    input  logic                 equalD,
    input  logic                 stallD,
    input  logic                 flushE,
    output logic                 branchD,
    output logic                 jumpD,
    output logic                 pcsrcD,
    output logic                 mdustallD,
    output logic                 illegalD,
    output logic                 regwriteE,
    output logic                 memtoregE,
    output logic                 jalE,
    output logic                 multstartE,
    output logic                 multsignE,
    output logic                 divE,
    output logic [ALUCTRL_W-1:0] alucontrolE,
    output logic [1:0]           alusrcE,
    output logic [1:0]           regdstE,
    output logic                 regwriteM,
    output logic                 memtoregM,
    output logic                 jalM,
    output logic                 memwriteM,
    output logic                 aluormultM,
    output logic                 lohiM,
    output logic                 regwriteW,
    output logic                 memtoregW,
    output logic                 jalW,
    output logic                 mdubusy
);

    localparam int unsigned CTRL_W = CTRL_BUNDLE_W - ALUCTRL_W_BASE + ALUCTRL_W;

    typedef struct packed {
        logic                 regwrite;
        logic                 memtoreg;
        logic                 jal;
        logic                 memwrite;
        logic [1:0]           alusrc;
        logic [1:0]           regdst;
        logic [ALUCTRL_W-1:0] alucontrol;
        logic                 multstart;
        logic                 multsign;
        logic                 aluormult;
        logic                 lohi;
`ifdef PIPELINE_CONTROLLER_DIV_EN
        logic                 div;
`endif
    } ctrl_t;

    typedef struct packed {
        logic regwrite;
        logic memtoreg;
        logic jal;
        logic memwrite;
        logic aluormult;
        logic lohi;
    } ctrl_m_t;

    typedef struct packed {
        logic regwrite;
        logic memtoreg;
        logic jal;
    } ctrl_w_t;

    ctrl_t       dec;
    aluop_e      aluop;
    logic        branch, bne, jump, mduop, illegal;
    logic        e_bubble;
    logic [CTRL_W-1:0] ctrl_e_q, ctrl_e_d;
    ctrl_t       e;
    ctrl_m_t     m_q, m_d;
    ctrl_w_t     w_q, w_d;

    // Main decoder; anything unrecognised stays an all-zero bundle
    always_comb begin
        dec     = '0;
        aluop   = AOP_NONE;
        branch  = 1'b0;
        bne     = 1'b0;
        jump    = 1'b0;
        mduop   = 1'b0;
        illegal = 1'b0;
        case (opD)
            OP_RTYPE: begin
                case (fnD)
                    FN_ADD, FN_SUB, FN_AND, FN_OR, FN_XOR, FN_XNOR, FN_SLT: begin
                        dec.regwrite = 1'b1;
                        dec.regdst   = DST_RD;
                        aluop        = AOP_FUNCT;
                    end
                    FN_MULT, FN_MULTU: begin
                        dec.multstart = 1'b1;
                        dec.multsign  = (fnD == FN_MULT);
                        mduop         = 1'b1;
                    end
                    FN_MFLO, FN_MFHI: begin
                        dec.regwrite  = 1'b1;
                        dec.regdst    = DST_RD;
                        dec.aluormult = 1'b1;
                        dec.lohi      = (fnD == FN_MFHI);
                        mduop         = 1'b1;
                    end
`ifdef PIPELINE_CONTROLLER_DIV_EN
                    FN_DIV, FN_DIVU: begin
                        dec.multstart = 1'b1;
                        dec.multsign  = (fnD == FN_DIV);
                        dec.div       = 1'b1;
                        mduop         = 1'b1;
                    end
`endif
                    default: illegal = 1'b1;
                endcase
            end
            OP_LW: begin
                dec.regwrite = 1'b1;
                dec.memtoreg = 1'b1;
                dec.alusrc   = SRC_SEXT;
                aluop        = AOP_ADD;
            end
            OP_SW: begin
                dec.memwrite = 1'b1;
                dec.alusrc   = SRC_SEXT;
                aluop        = AOP_ADD;
            end
            OP_BEQ, OP_BNE: begin
                branch = 1'b1;
                bne    = (opD == OP_BNE);
                aluop  = AOP_SUB;
            end
            OP_ADDI: begin
                dec.regwrite = 1'b1;
                dec.alusrc   = SRC_SEXT;
                aluop        = AOP_ADD;
            end
            OP_J: jump = 1'b1;
            OP_JAL: begin
                jump         = 1'b1;
                dec.regwrite = 1'b1;
                dec.jal      = 1'b1;
                dec.regdst   = DST_RA;
            end
            OP_ORI, OP_ANDI, OP_XORI: begin
                dec.regwrite = 1'b1;
                dec.alusrc   = SRC_ZEXT;
                aluop        = (opD == OP_ORI)  ? AOP_OR  :
                               (opD == OP_ANDI) ? AOP_AND : AOP_XOR;
            end
            OP_SLTI: begin
                dec.regwrite = 1'b1;
                dec.alusrc   = SRC_SEXT;
                aluop        = AOP_SLT;
            end
            OP_LUI: begin
                dec.regwrite = 1'b1;
                dec.alusrc   = SRC_UPPER;
                aluop        = AOP_ADD;
            end
            default: illegal = 1'b1;
        endcase
        dec.alucontrol = ALUCTRL_W'(aluop_ctrl(aluop, fnD));
    end

    mdu_scoreboard #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_mdu (
        .clk         (clk),
        .rst         (rst),
        .mduop_i     (mduop),
        .multstart_i (e.multstart),
        .div_i       (divE),
        .busy_o      (mdubusy),
        .stall_o     (mdustallD)
    );

    // Decode-stage redirects are suppressed while the MDU interlock holds D
    assign branchD  = branch & ~mdustallD;
    assign jumpD    = jump & ~mdustallD;
    assign pcsrcD   = branchD & (bne ^ equalD);
    assign illegalD = illegal;

    assign e_bubble = flushE | stallD | mdustallD;

    // E gets a zero bubble on any flush or stall, else the decoded bundle
    always_comb begin
        ctrl_e_d = e_bubble ? '0 : dec;
    end

    assign e = ctrl_t'(ctrl_e_q);

    // M and W simply forward the fields later stages still need
    always_comb begin
        m_d = '{regwrite: e.regwrite, memtoreg: e.memtoreg, jal: e.jal,
                memwrite: e.memwrite, aluormult: e.aluormult, lohi: e.lohi};
        w_d = '{regwrite: m_q.regwrite, memtoreg: m_q.memtoreg, jal: m_q.jal};
    end

    // Pipeline registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_e_q <= '0;
            m_q      <= '0;
            w_q      <= '0;
        end else begin
            ctrl_e_q <= ctrl_e_d;
            m_q      <= m_d;
            w_q      <= w_d;
        end
    end

    assign regwriteE   = e.regwrite;
    assign memtoregE   = e.memtoreg;
    assign jalE        = e.jal;
    assign multstartE  = e.multstart;
    assign multsignE   = e.multsign;
    assign alucontrolE = e.alucontrol;
    assign alusrcE     = e.alusrc;
    assign regdstE     = e.regdst;
`ifdef PIPELINE_CONTROLLER_DIV_EN
    assign divE        = e.div;
`else
    assign divE        = 1'b0;
`endif

    assign regwriteM  = m_q.regwrite;
    assign memtoregM  = m_q.memtoreg;
    assign jalM       = m_q.jal;
    assign memwriteM  = m_q.memwrite;
    assign aluormultM = m_q.aluormult;
    assign lohiM      = m_q.lohi;

    assign regwriteW = w_q.regwrite;
    assign memtoregW = w_q.memtoreg;
    assign jalW      = w_q.jal;

endmodule
